spi_master_mm: RTL and testbench

//  Memory-mapped SPI master; successor to the fixed SD-card SPI engine in the SoC.

---
 rtl/spi_master_mm.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_master_mm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mm.sv
// spi_master_mm: memory-mapped SPI master for the CPU data bus.
// Run-time programmable SCLK divider, SPI modes 0-3, TX/RX FIFOs and
// NUM_CS software-driven chip selects. Frames are DATA_W bits, MSB first.
// Optional feature: define SPI_IRQ_EN to add the registered irq output
// together with the CTRL[3] rx_ie and CTRL[4] txe_ie enables.
module spi_master_mm #(
    parameter int NUM_CS     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [1:0]        addr,
    input  logic [31:0]       data_wr,
    input  logic              mem_wr,
    input  logic              mem_rd,
    output logic [31:0]       data_rd,
    output logic              sd_clk,
    output logic              sd_mosi,
    input  logic              sd_miso,
    output logic [NUM_CS-1:0] sd_cs_n
`ifdef SPI_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {A_DATA, A_STATUS, A_CTRL, A_CS} reg_addr_e;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

    // Bus decode
    reg_addr_e addr_e;
    logic      bus_wr, bus_rd;
    assign addr_e = reg_addr_e'(addr);
    assign bus_wr = sel && mem_wr;
    assign bus_rd = sel && mem_rd;

    // Control / status registers
    logic              en_q, cpol_q, cpha_q;
    logic [DIV_W-1:0]  div_q;
    logic [NUM_CS-1:0] cs_q;
    logic              tx_ovf_q, rx_ovf_q;
`ifdef SPI_IRQ_EN
    logic              rx_ie_q, txe_ie_q, irq_q;
`endif

    // FIFO storage and pointers
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]     tx_cnt_q, rx_cnt_q;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_acc, rx_push, rx_pop, rx_acc;

    // Shift engine
    state_e            state_q;
    logic              sclk_q, mosi_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
    logic [DIV_W-1:0]  hcnt_q, w_div_q;
    logic [EW-1:0]     edge_q;
    logic              w_cpol_q, w_cpha_q;
    logic              busy, edge_lead, edge_last;

    logic [31:0] rd_val_d, data_rd_q;
    logic        unused_data_wr;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    assign busy    = (state_q != S_IDLE);
    assign tx_push = bus_wr && (addr_e == A_DATA);
    assign tx_pop  = (state_q == S_IDLE) && en_q && !tx_empty;
    // A push into a full FIFO still lands if the other side frees a slot this cycle.
    assign tx_acc  = tx_push && (!tx_full || tx_pop);
    assign rx_push = (state_q == S_DONE);
    assign rx_pop  = bus_rd && (addr_e == A_DATA) && !rx_empty;
    assign rx_acc  = rx_push && (!rx_full || rx_pop);

    assign edge_lead = !edge_q[0];
    assign edge_last = (edge_q == LAST_EDGE);

    // Only some write-data bits are mapped; the rest are deliberately ignored.
    assign unused_data_wr = ^data_wr;

    // Register writes from the bus and sticky overflow flags.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            cs_q     <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
`ifdef SPI_IRQ_EN
            rx_ie_q  <= 1'b0;
            txe_ie_q <= 1'b0;
`endif
        end else begin
            if (bus_wr && addr_e == A_CTRL) begin
                en_q   <= data_wr[0];
                cpol_q <= data_wr[1];
                cpha_q <= data_wr[2];
                div_q  <= data_wr[DIV_W+7:8];
`ifdef SPI_IRQ_EN
                rx_ie_q  <= data_wr[3];
                txe_ie_q <= data_wr[4];
`endif
            end
            if (bus_wr && addr_e == A_CS) cs_q <= data_wr[NUM_CS-1:0];
            // A new overflow wins over a simultaneous clear so no event is lost.
            if (tx_push && tx_full && !tx_pop)                    tx_ovf_q <= 1'b1;
            else if (bus_wr && addr_e == A_STATUS && data_wr[5]) tx_ovf_q <= 1'b0;
            if (rx_push && rx_full && !rx_pop)                    rx_ovf_q <= 1'b1;
            else if (bus_wr && addr_e == A_STATUS && data_wr[6]) rx_ovf_q <= 1'b0;
        end
    end

    // FIFO data arrays: written only on accepted pushes.
    // NOTE: storage is not reset; the counts alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_acc) tx_mem[tx_wp_q] <= data_wr[DATA_W-1:0];
        if (rx_acc) rx_mem[rx_wp_q] <= rx_sh_q;
    end

    // FIFO pointers and occupancy counts; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_acc) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop) tx_rp_q <= tx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_q + CW'(tx_acc) - CW'(tx_pop);
            if (rx_acc) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop) rx_rp_q <= rx_rp_q + AW'(1);
            rx_cnt_q <= rx_cnt_q + CW'(rx_acc) - CW'(rx_pop);
        end
    end

    // Frame engine: IDLE pops a word, LOAD freezes the mode, SHIFT toggles SCLK, DONE hands off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            hcnt_q   <= '0;
            edge_q   <= '0;
            w_cpol_q <= 1'b0;
            w_cpha_q <= 1'b0;
            w_div_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    sclk_q <= cpol_q;
                    mosi_q <= 1'b1;
                    if (tx_pop) begin
                        tx_sh_q <= tx_mem[tx_rp_q];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_cpol_q <= cpol_q;
                    w_cpha_q <= cpha_q;
                    w_div_q  <= div_q;
                    sclk_q   <= cpol_q;
                    hcnt_q   <= '0;
                    edge_q   <= '0;
                    // With cpha=0 the slave samples on the first edge, so the MSB must already be out.
                    if (!cpha_q) begin
                        mosi_q  <= tx_sh_q[DATA_W-1];
                        tx_sh_q <= tx_sh_q << 1;
                    end
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (hcnt_q == w_div_q) begin
                        hcnt_q <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EW'(1);
                        if (w_cpha_q ? edge_lead : (!edge_lead && !edge_last)) begin
                            mosi_q  <= tx_sh_q[DATA_W-1];
                            tx_sh_q <= tx_sh_q << 1;
                        end
                        if (w_cpha_q ? !edge_lead : edge_lead)
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], sd_miso};
                        if (edge_last) state_q <= S_DONE;
                    end else begin
                        hcnt_q <= hcnt_q + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    mosi_q  <= 1'b1;
                    sclk_q  <= w_cpol_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-data mux; unmapped bits and an empty RX FIFO read as zero.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        rd_val_d = '0;
        case (addr_e)
            A_DATA:   if (!rx_empty) rd_val_d[DATA_W-1:0] = rx_mem[rx_rp_q];
            A_STATUS: rd_val_d[6:0] = {rx_ovf_q, tx_ovf_q, rx_empty, rx_full,
                                       tx_empty, tx_full, busy};
            A_CTRL: begin
                rd_val_d[0] = en_q;
                rd_val_d[1] = cpol_q;
                rd_val_d[2] = cpha_q;
`ifdef SPI_IRQ_EN
                rd_val_d[3] = rx_ie_q;
                rd_val_d[4] = txe_ie_q;
`endif
                rd_val_d[DIV_W+7:8] = div_q;
            end
            A_CS:     rd_val_d[NUM_CS-1:0] = cs_q;
            default:  rd_val_d = '0;
        endcase
    end

    // Registered read port: valid the cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      data_rd_q <= '0;
        else if (bus_rd) data_rd_q <= rd_val_d;
    end

`ifdef SPI_IRQ_EN
    // Interrupt: level of the enabled conditions, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= (rx_ie_q && !rx_empty) || (txe_ie_q && tx_empty && !busy) ||
                             tx_ovf_q || rx_ovf_q;
    end
    assign irq = irq_q;
`endif

    assign data_rd = data_rd_q;
    assign sd_clk  = sclk_q;
    assign sd_mosi = mosi_q;
    assign sd_cs_n = ~cs_q;

endmodule

// File: tb/tb_spi_master_mm.sv
// Testbench for spi_master_mm: register-access vector table, then directed
// sequences for SPI modes, FIFO/overflow behaviour, chip select, irq and
// mid-frame reset. A small SPI slave model drives MISO and captures MOSI.
`timescale 1ns/1ps
module tb_spi_master_mm;

    localparam int NUM_CS     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 8;
    localparam int DIV_W      = 8;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_CS     = 2'd3;

`ifdef SPI_IRQ_EN
    localparam logic [31:0] CTRL_ALL = 32'h0000_FF1F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0000_FF07;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sel = 1'b0;
    logic [1:0]        addr = 2'd0;
    logic [31:0]       data_wr = '0;
    logic              mem_wr = 1'b0;
    logic              mem_rd = 1'b0;
    logic [31:0]       data_rd;
    logic              sd_clk, sd_mosi, sd_miso;
    logic [NUM_CS-1:0] sd_cs_n;
`ifdef SPI_IRQ_EN
    logic              irq;
`endif

    int checks   = 0;
    int failures = 0;

    spi_master_mm #(
        .NUM_CS(NUM_CS), .FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .data_wr(data_wr),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .data_rd(data_rd), .sd_clk(sd_clk),
        .sd_mosi(sd_mosi), .sd_miso(sd_miso), .sd_cs_n(sd_cs_n)
`ifdef SPI_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- SPI slave model ----------------
    logic       loop_en = 1'b0;
    logic       s_cpol = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] s_word = 8'h00;
    logic [7:0] m_word = 8'h00;
    int         s_shifts = 0;
    int         s_base = 0;
    int         s_pos;
    logic       s_out;

    // Slave shifts its output on the edge the master does not sample on, and
    // captures MOSI on the edge the master samples MISO on.
    always @(sd_clk) begin
        if ((sd_clk != s_cpol) == s_cpha) s_shifts <= s_shifts + 1;
        else                              m_word   <= {m_word[6:0], sd_mosi};
    end

    always_comb begin
        s_pos = s_shifts - s_base - (s_cpha ? 1 : 0);
        s_out = 1'b1;
        if (s_pos >= 0 && s_pos < 8) s_out = s_word[7 - s_pos];
    end

    assign sd_miso = loop_en ? sd_mosi : s_out;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic s);
        @(negedge clk);
        sel = s; addr = a; data_wr = d; mem_wr = 1'b1;
        @(negedge clk);
        sel = 1'b0; mem_wr = 1'b0; data_wr = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; mem_rd = 1'b1;
        @(negedge clk);
        sel = 1'b0; mem_rd = 1'b0;
        d = data_rd;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    // One frame in the given mode; monitors busy via continuous STATUS reads and SCLK shape.
    task automatic run_frame(input logic cpol, input logic cpha, input int div,
                             input logic [7:0] tx, input logic loop,
                             input logic [7:0] slave, input logic [7:0] exp_rx,
                             input string name);
        logic [31:0] ctrl;
        logic        prev;
        int          busy_n, act_n, edges_n, budget;
        ctrl = (32'(div) << 8) | (32'(cpha) << 2) | (32'(cpol) << 1);
        s_cpol = cpol; s_cpha = cpha; loop_en = loop; s_word = slave;
        bus_write(A_CTRL, ctrl, 1'b1);
        repeat (2) @(negedge clk);
        check({name, "_idle_sclk"}, 32'(sd_clk), 32'(cpol));
        s_base = s_shifts;
        bus_write(A_DATA, 32'(tx), 1'b1);
        bus_write(A_CTRL, ctrl | 32'h1, 1'b1);
        sel = 1'b1; addr = A_STATUS; mem_rd = 1'b1;
        busy_n = 0; act_n = 0; edges_n = 0; prev = cpol;
        budget = 2 * DATA_W * (div + 1) + 30;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (data_rd[0]) busy_n++;
            if (sd_clk != cpol) begin
                act_n++;
                if (prev == cpol) edges_n++;
            end
            prev = sd_clk;
        end
        sel = 1'b0; mem_rd = 1'b0;
        bus_write(A_CTRL, ctrl, 1'b1);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(2 * DATA_W * (div + 1) + 2));
        check({name, "_sclk_active"}, 32'(act_n), 32'(DATA_W * (div + 1)));
        check({name, "_sclk_periods"}, 32'(edges_n), 32'(DATA_W));
        check({name, "_end_sclk"}, 32'(sd_clk), 32'(cpol));
        check({name, "_end_mosi"}, 32'(sd_mosi), 32'h1);
        check({name, "_mosi_seen"}, 32'(m_word), 32'(tx));
        read_check({name, "_rx"}, A_DATA, 32'(exp_rx));
        loop_en = 1'b0;
    endtask

    // ---------------- register-access vector table ----------------
    typedef struct {
        logic        wr;
        logic        s;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, A_STATUS, 32'h0,         32'h14,   "status_reset"};
        vecs[1]  = '{1'b0, 1'b1, A_CTRL,   32'h0,         32'h0,    "ctrl_reset"};
        vecs[2]  = '{1'b0, 1'b1, A_CS,     32'h0,         32'h0,    "cs_reset"};
        vecs[3]  = '{1'b0, 1'b1, A_DATA,   32'h0,         32'h0,    "data_empty"};
        vecs[4]  = '{1'b1, 1'b1, A_CTRL,   32'hFFFF_FFFF, 32'h0,    ""};
        vecs[5]  = '{1'b0, 1'b1, A_CTRL,   32'h0,         CTRL_ALL, "ctrl_mapped_bits"};
        vecs[6]  = '{1'b1, 1'b1, A_CTRL,   32'h0,         32'h0,    ""};
        vecs[7]  = '{1'b1, 1'b0, A_CTRL,   32'h5,         32'h0,    ""};
        vecs[8]  = '{1'b0, 1'b1, A_CTRL,   32'h0,         32'h0,    "ctrl_nosel"};
        vecs[9]  = '{1'b1, 1'b1, A_CS,     32'hFFFF_FFFF, 32'h0,    ""};
        vecs[10] = '{1'b0, 1'b1, A_CS,     32'h0,         32'h3,    "cs_mapped_bits"};
        vecs[11] = '{1'b1, 1'b1, A_CS,     32'h0,         32'h0,    ""};
        vecs[12] = '{1'b1, 1'b1, A_STATUS, 32'hFFFF_FFFF, 32'h0,    ""};
        vecs[13] = '{1'b0, 1'b1, A_STATUS, 32'h0,         32'h14,   "status_ro_bits"};
        vecs[14] = '{1'b0, 1'b1, A_CS,     32'h0,         32'h0,    "cs_still_zero"};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sd_clk), 32'h0);
        check("rst_mosi", 32'(sd_mosi), 32'h1);
        check("rst_cs_n", 32'(sd_cs_n), 32'h3);
        check("rst_data_rd", data_rd, 32'h0);
`ifdef SPI_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d, vecs[i].s);
            else            read_check(vecs[i].name, vecs[i].a, vecs[i].exp);
        end

        // SPI modes.
        run_frame(1'b0, 1'b0, 0, 8'hA5, 1'b1, 8'h00, 8'hA5, "mode0");
        run_frame(1'b0, 1'b1, 3, 8'h3C, 1'b0, 8'hC3, 8'hC3, "mode1");
        run_frame(1'b1, 1'b0, 3, 8'h3C, 1'b0, 8'hC3, 8'hC3, "mode2");
        run_frame(1'b1, 1'b1, 3, 8'h3C, 1'b0, 8'hC3, 8'hC3, "mode3");

        // TX FIFO fill and overflow with the engine disabled, then drain in order.
        bus_write(A_CTRL, 32'h0, 1'b1);
        loop_en = 1'b1;
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, 32'(i * 8'h11), 1'b1);
        read_check("tx_full_ovf", A_STATUS, 32'h32);
        bus_write(A_CTRL, 32'h1, 1'b1);
        repeat (120) @(negedge clk);
        read_check("tx_drained_rx_full", A_STATUS, 32'h2C);
        bus_write(A_STATUS, 32'h20, 1'b1);
        read_check("tx_ovf_cleared", A_STATUS, 32'h0C);
        bus_write(A_CTRL, 32'h0, 1'b1);
        for (int i = 1; i <= 4; i++) read_check("fifo_order", A_DATA, 32'(i * 8'h11));
        read_check("fifo_empty_again", A_STATUS, 32'h14);

        // RX overflow: five frames, no reads.
        bus_write(A_DATA, 32'h01, 1'b1);
        bus_write(A_DATA, 32'h80, 1'b1);
        bus_write(A_DATA, 32'hFF, 1'b1);
        bus_write(A_DATA, 32'h5A, 1'b1);
        bus_write(A_CTRL, 32'h1, 1'b1);
        bus_write(A_DATA, 32'h77, 1'b1);
        repeat (150) @(negedge clk);
        read_check("rx_ovf_status", A_STATUS, 32'h4C);
        bus_write(A_CTRL, 32'h0, 1'b1);
        read_check("rx_word0", A_DATA, 32'h01);
        read_check("rx_word1", A_DATA, 32'h80);
        read_check("rx_word2", A_DATA, 32'hFF);
        read_check("rx_word3", A_DATA, 32'h5A);
        read_check("rx_word4_dropped", A_DATA, 32'h0);
        read_check("rx_ovf_sticky", A_STATUS, 32'h54);
        bus_write(A_STATUS, 32'h40, 1'b1);
        read_check("rx_ovf_cleared", A_STATUS, 32'h14);

        // en and divider changes mid-frame: current frame finishes, next one waits.
        bus_write(A_DATA, 32'h96, 1'b1);
        bus_write(A_DATA, 32'h69, 1'b1);
        bus_write(A_CTRL, 32'h301, 1'b1);
        repeat (5) @(negedge clk);
        bus_write(A_CTRL, 32'h0, 1'b1);
        repeat (100) @(negedge clk);
        read_check("en_off_holds", A_STATUS, 32'h00);
        read_check("en_off_frame_done", A_DATA, 32'h96);
        bus_write(A_CTRL, 32'h1, 1'b1);
        repeat (40) @(negedge clk);
        bus_write(A_CTRL, 32'h0, 1'b1);
        read_check("en_on_resumes", A_DATA, 32'h69);
        loop_en = 1'b0;

        // Chip selects.
        bus_write(A_CS, 32'h2, 1'b1);
        check("cs_n_0b01", 32'(sd_cs_n), 32'h1);
        bus_write(A_CS, 32'h0, 1'b1);
        check("cs_n_idle", 32'(sd_cs_n), 32'h3);

`ifdef SPI_IRQ_EN
        // Receive interrupt: rises once a word is received, falls after it is read.
        loop_en = 1'b1;
        bus_write(A_CTRL, 32'h9, 1'b1);
        check("irq_quiet", 32'(irq), 32'h0);
        bus_write(A_DATA, 32'h5A, 1'b1);
        repeat (30) @(negedge clk);
        check("irq_rx_rise", 32'(irq), 32'h1);
        read_check("irq_rx_data", A_DATA, 32'h5A);
        @(negedge clk);
        check("irq_rx_fall", 32'(irq), 32'h0);
        bus_write(A_CTRL, 32'h0, 1'b1);
        loop_en = 1'b0;
`endif

        // Reset asserted in the middle of a frame.
        loop_en = 1'b1;
        bus_write(A_CTRL, 32'h301, 1'b1);
        bus_write(A_CS, 32'h1, 1'b1);
        bus_write(A_DATA, 32'hF0, 1'b1);
        repeat (20) @(negedge clk);
        check("midframe_cs_n", 32'(sd_cs_n), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(sd_cs_n), 32'h3);
        check("abort_sclk", 32'(sd_clk), 32'h0);
        check("abort_mosi", 32'(sd_mosi), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_check("abort_status", A_STATUS, 32'h14);
        repeat (80) @(negedge clk);
        read_check("abort_no_rx", A_DATA, 32'h0);
        loop_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
